// File: rtl/cp_s1_pkg.sv
// rtl/cp_s1_pkg.sv - shared types and sizes for the S1 write scheduler
package cp_s1_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } sched_st_t;

    localparam int NUM_REQ  = 2;
    localparam int NUM_BANK = 2;

endpackage

// File: rtl/cp_s1_rr_arb.sv
// rtl/cp_s1_rr_arb.sv - two-way round-robin pick with pointer update on enable
module cp_s1_rr_arb
    import cp_s1_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               upd_en,
    input  logic               upd_last,
    output logic               winner
);

    logic ptr;

    // Pointer moves to the requester that was not just served
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (upd_en) begin
            ptr <= ~upd_last;
        end
    end

    // Pointer requester wins when it is asking, otherwise the other one
    always_comb begin
        winner = req[ptr] ? ptr : ~ptr;
    end

endmodule

// File: rtl/cp_s1_wr_sched.sv
// rtl/cp_s1_wr_sched.sv - frame-granular ping-pong write scheduler for the S1 sample RAM
module cp_s1_wr_sched
    import cp_s1_pkg::*;
#(
    parameter int READ_RAM_WIDTH = 128,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_NUM       = 1024,
    parameter int INIT_ADDR      = 0,
    parameter int ADD_ADDR       = 16,
    parameter int BANK_SIZE      = 16384
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [READ_RAM_WIDTH-1:0] i_req_data [0:NUM_REQ-1],
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ-1:0]        i_req_last,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [READ_RAM_WIDTH-1:0] o_wr_data,
    output logic [ADDR_WIDTH-1:0]     o_wr_addr,
    output logic                      o_wr_en,
    output logic [READ_RAM_WIDTH-1:0] o_wr_wea,
    output logic                      o_frame_done,
    output logic                      o_frame_bank,
    output logic                      o_frame_src,
    output logic                      o_frame_err,
    input  logic [NUM_BANK-1:0]       i_bank_release,
    output logic [NUM_BANK-1:0]       o_bank_full
);

    localparam int                    CW       = $clog2(DATA_NUM) + 1;
    localparam logic [CW-1:0]         LAST_CNT = CW'(DATA_NUM);
    localparam logic [ADDR_WIDTH-1:0] BASE0    = ADDR_WIDTH'(INIT_ADDR);
    localparam logic [ADDR_WIDTH-1:0] BASE1    = BASE0 + ADDR_WIDTH'(BANK_SIZE);
    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(ADD_ADDR);

    sched_st_t             state;
    sched_st_t             state_nxt;
    logic                  grant;
    logic                  fill_bank;
    logic [NUM_BANK-1:0]   full;
    logic [CW-1:0]         beat_cnt;
    logic [CW-1:0]         cnt_inc;
    logic [ADDR_WIDTH-1:0] wr_off;
    logic [ADDR_WIDTH-1:0] bank_base;
    logic                  arb_win;
    logic                  accept;
    logic                  frame_end;
    logic                  frame_err;
    logic                  start;

    cp_s1_rr_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (i_req_valid),
        .upd_en   (state == DONE),
        .upd_last (grant),
        .winner   (arb_win)
    );

    // Beat handshake and frame-end classification for the granted requester
    always_comb begin
        accept    = (state == XFER) && i_req_valid[grant];
        cnt_inc   = beat_cnt + 1'b1;
        frame_end = accept && (i_req_last[grant] || (cnt_inc == LAST_CNT));
        frame_err = !(i_req_last[grant] && (cnt_inc == LAST_CNT));
        bank_base = fill_bank ? BASE1 : BASE0;
        start     = (state == IDLE) && (state_nxt == XFER);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and ready; a new frame only starts into an empty bank
    always_comb begin
        state_nxt   = state;
        o_req_ready = '0;
        case (state)
            IDLE: begin
                if ((|i_req_valid) && !full[fill_bank]) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                o_req_ready[grant] = 1'b1;
                if (frame_end) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant, beat counter and the registered RAM write port
    always_ff @(posedge clk) begin
        if (rst) begin
            grant        <= 1'b0;
            fill_bank    <= 1'b0;
            beat_cnt     <= '0;
            wr_off       <= '0;
            o_wr_en      <= 1'b0;
            o_wr_data    <= '0;
            o_wr_addr    <= BASE0;
            o_frame_done <= 1'b0;
            o_frame_bank <= 1'b0;
            o_frame_src  <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_wr_en      <= accept;
            o_frame_done <= frame_end;
            o_frame_bank <= frame_end & fill_bank;
            o_frame_src  <= frame_end & grant;
            o_frame_err  <= frame_end & frame_err;
            if (start) begin
                grant    <= arb_win;
                beat_cnt <= '0;
                wr_off   <= '0;
            end
            if (accept) begin
                o_wr_data <= i_req_data[grant];
                o_wr_addr <= bank_base + wr_off;
                wr_off    <= wr_off + STEP;
                beat_cnt  <= cnt_inc;
            end
            if (state == DONE) begin
                fill_bank <= ~fill_bank;
            end
        end
    end

    // Bank occupancy: filled on DONE, freed by the reader; filling wins a tie
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
        end else begin
            for (int b = 0; b < NUM_BANK; b++) begin
                if ((state == DONE) && (fill_bank == 1'(b))) begin
                    full[b] <= 1'b1;
                end else if (i_bank_release[b]) begin
                    full[b] <= 1'b0;
                end
            end
        end
    end

    assign o_wr_wea    = {READ_RAM_WIDTH{o_wr_en}};
    assign o_bank_full = full;

endmodule
